debug_frame_rx: RTL and testbench



---
 rtl/debug_frame_rx.sv | 156 +++++++++++++++
 tb/tb_debug_frame_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : debug_frame_rx
// Brief    : Debug UART command-frame parser (sync hunt, checksum, handshake).
// Revision : 1.0
// ============================================================================
module debug_frame_rx #(
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter logic [7:0] SYNC0          = 8'h5A,
   parameter logic [7:0] SYNC1          = 8'hA5
) (
   input  logic        clk,
   input  logic        sync_reset,
   input  logic        rx_enable,
   input  logic        rx_byte_valid,
   input  logic [7:0]  rx_byte,
   output logic        frame_valid,
   input  logic        frame_ready,
   output logic [7:0]  frame_cmd,
   output logic [31:0] frame_addr,
   output logic [31:0] frame_data,
   output logic        frame_error,
   output logic [1:0]  err_code
);

   localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES);

   localparam logic [2:0] S_SYNC0 = 3'd0;
   localparam logic [2:0] S_SYNC1 = 3'd1;
   localparam logic [2:0] S_CMD   = 3'd2;
   localparam logic [2:0] S_ADDR  = 3'd3;
   localparam logic [2:0] S_DATA  = 3'd4;
   localparam logic [2:0] S_CSUM  = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [7:0]    sum_q, sum_d;
   logic [7:0]    cmd_sh_q;
   logic [31:0]   addr_sh_q, data_sh_q;
   logic          valid_q, err_q;
   logic [1:0]    code_q;

   logic       w_byte, w_timeout, w_good, w_bad, w_load, w_overrun;
   logic [7:0] w_sum_final;

   assign w_byte      = rx_enable & rx_byte_valid;
   assign w_sum_final = sum_q + rx_byte;
   // A byte landing on the limit cycle wins over the timeout.
   assign w_timeout   = rx_enable & (state_q != S_SYNC0) & ~w_byte & (cnt_q == TO_LAST);

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q <= S_SYNC0;
         idx_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      if (!rx_enable) begin
         state_d = S_SYNC0;
         idx_d   = 2'd0;
      end else if (w_byte) begin
         case (state_q)
            S_SYNC0: if (rx_byte == SYNC0) state_d = S_SYNC1;
            S_SYNC1: begin
               if (rx_byte == SYNC1)      state_d = S_CMD;
               else if (rx_byte != SYNC0) state_d = S_SYNC0;
            end
            S_CMD: begin
               state_d = S_ADDR;
               idx_d   = 2'd0;
            end
            S_ADDR: begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = S_DATA;
            end
            S_DATA: begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) state_d = S_CSUM;
            end
            default: state_d = S_SYNC0;
         endcase
      end else if (w_timeout) begin
         state_d = S_SYNC0;
      end
   end

   always_comb begin
      w_good    = w_byte & (state_q == S_CSUM) & (w_sum_final == 8'h00);
      w_bad     = w_byte & (state_q == S_CSUM) & (w_sum_final != 8'h00);
      w_load    = w_good & (~valid_q | frame_ready);
      w_overrun = w_good & valid_q & ~frame_ready;

      sum_d = sum_q;
      if (w_byte) begin
         case (state_q)
            S_CMD:          sum_d = rx_byte;
            S_ADDR, S_DATA: sum_d = w_sum_final;
            S_CSUM:         sum_d = 8'h00;
            default:        sum_d = sum_q;
         endcase
      end

      cnt_d = cnt_q;
      if (!rx_enable || w_byte || w_timeout || state_q == S_SYNC0) cnt_d = '0;
      else if (cnt_q != TO_MAX)                                     cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (sync_reset) begin
         cnt_q      <= '0;
         sum_q      <= 8'h00;
         cmd_sh_q   <= 8'h00;
         addr_sh_q  <= 32'h0;
         data_sh_q  <= 32'h0;
         valid_q    <= 1'b0;
         frame_cmd  <= 8'h00;
         frame_addr <= 32'h0;
         frame_data <= 32'h0;
         err_q      <= 1'b0;
         code_q     <= 2'b00;
      end else begin
         cnt_q <= cnt_d;
         sum_q <= sum_d;
         if (w_byte && state_q == S_CMD)  cmd_sh_q  <= rx_byte;
         if (w_byte && state_q == S_ADDR) addr_sh_q <= {addr_sh_q[23:0], rx_byte};
         if (w_byte && state_q == S_DATA) data_sh_q <= {data_sh_q[23:0], rx_byte};
         if (w_load) begin
            valid_q    <= 1'b1;
            frame_cmd  <= cmd_sh_q;
            frame_addr <= addr_sh_q;
            frame_data <= data_sh_q;
         end else if (valid_q && frame_ready) begin
            valid_q <= 1'b0;
         end
         err_q <= w_bad | w_timeout | w_overrun;
         if (w_bad)          code_q <= 2'b01;
         else if (w_timeout) code_q <= 2'b10;
         else if (w_overrun) code_q <= 2'b11;
      end
   end

   assign frame_valid = valid_q;
   assign frame_error = err_q;
   assign err_code    = code_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_frame_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_frame_rx
// Brief    : Directed self-checking bench for debug_frame_rx.
// Revision : 1.0
// ============================================================================
module tb_debug_frame_rx;

   logic        clk = 1'b0;
   logic        sync_reset, rx_enable, rx_byte_valid, frame_ready;
   logic [7:0]  rx_byte;
   logic        frame_valid, frame_error;
   logic [7:0]  frame_cmd;
   logic [31:0] frame_addr, frame_data;
   logic [1:0]  err_code;

   int n_pass = 0;
   int n_total = 0;
   int err_seen = 0;

   debug_frame_rx #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .sync_reset(sync_reset), .rx_enable(rx_enable),
      .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
      .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_cmd(frame_cmd), .frame_addr(frame_addr), .frame_data(frame_data),
      .frame_error(frame_error), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // Counts error-pulse cycles (value held during the cycle before each edge).
   always @(posedge clk) if (frame_error === 1'b1) err_seen++;

   task automatic send_byte(input logic [7:0] b);
      rx_byte       = b;
      rx_byte_valid = 1'b1;
      @(negedge clk);
      rx_byte_valid = 1'b0;
   endtask

   task automatic send_payload(input logic [7:0] cmd, input logic [31:0] addr,
                               input logic [31:0] data, input logic [7:0] csum,
                               input bit ready_on_csum);
      send_byte(cmd);
      for (int i = 3; i >= 0; i--) send_byte(addr[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8]);
      frame_ready = ready_on_csum;
      send_byte(csum);
      frame_ready = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr,
                             input logic [31:0] data, input logic [7:0] csum,
                             input bit ready_on_csum);
      send_byte(8'h5A);
      send_byte(8'hA5);
      send_payload(cmd, addr, data, csum, ready_on_csum);
   endtask

   task automatic consume();
      frame_ready = 1'b1;
      @(negedge clk);
      frame_ready = 1'b0;
   endtask

   task automatic test_reset();
      sync_reset = 1'b1;
      repeat (3) @(negedge clk);
      sync_reset = 1'b0;
      @(negedge clk);
      n_total++; if (frame_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", frame_valid); else n_pass++;
      n_total++; if (frame_cmd !== 8'h00) $display("FAIL reset_cmd got %h want 00", frame_cmd); else n_pass++;
      n_total++; if (frame_addr !== 32'h0) $display("FAIL reset_addr got %h want 0", frame_addr); else n_pass++;
      n_total++; if (frame_data !== 32'h0) $display("FAIL reset_data got %h want 0", frame_data); else n_pass++;
      n_total++; if (frame_error !== 1'b0) $display("FAIL reset_error got %b want 0", frame_error); else n_pass++;
      n_total++; if (err_code !== 2'b00) $display("FAIL reset_code got %b want 00", err_code); else n_pass++;
   endtask

   task automatic test_good_frame();
      int e0 = err_seen;
      send_byte(8'h5A); send_byte(8'hA5);
      send_byte(8'h01);
      for (int i = 0; i < 8; i++) send_byte(8'h00 + ((i == 2) ? 8'h10 : (i >= 4) ? (8'h12 + 8'h22 * i[7:0] - 8'h88) : 8'h00));
      n_total++; if (frame_valid !== 1'b0) $display("FAIL good_pre_csum_valid got %b want 0", frame_valid); else n_pass++;
      send_byte(8'hDB);
      n_total++; if (frame_valid !== 1'b1) $display("FAIL good_valid got %b want 1", frame_valid); else n_pass++;
      n_total++; if (frame_cmd !== 8'h01) $display("FAIL good_cmd got %h want 01", frame_cmd); else n_pass++;
      n_total++; if (frame_addr !== 32'h0000_1000) $display("FAIL good_addr got %h want 00001000", frame_addr); else n_pass++;
      n_total++; if (frame_data !== 32'h1234_5678) $display("FAIL good_data got %h want 12345678", frame_data); else n_pass++;
      repeat (2) @(negedge clk);
      n_total++; if (frame_valid !== 1'b1) $display("FAIL good_hold_valid got %b want 1", frame_valid); else n_pass++;
      consume();
      n_total++; if (frame_valid !== 1'b0) $display("FAIL good_accept_valid got %b want 0", frame_valid); else n_pass++;
      n_total++; if (err_seen !== e0) $display("FAIL good_no_error got %0d want %0d", err_seen, e0); else n_pass++;
   endtask

   task automatic test_bad_csum();
      int e0 = err_seen;
      send_frame(8'h01, 32'h0000_1000, 32'h1234_5678, 8'hDC, 1'b0);
      n_total++; if (frame_error !== 1'b1) $display("FAIL csum_error got %b want 1", frame_error); else n_pass++;
      n_total++; if (err_code !== 2'b01) $display("FAIL csum_code got %b want 01", err_code); else n_pass++;
      n_total++; if (frame_valid !== 1'b0) $display("FAIL csum_valid got %b want 0", frame_valid); else n_pass++;
      @(negedge clk);
      n_total++; if (frame_error !== 1'b0) $display("FAIL csum_pulse_width got %b want 0", frame_error); else n_pass++;
      n_total++; if (err_seen !== e0 + 1) $display("FAIL csum_pulse_count got %0d want %0d", err_seen, e0 + 1); else n_pass++;
      n_total++; if (err_code !== 2'b01) $display("FAIL csum_code_sticky got %b want 01", err_code); else n_pass++;
   endtask

   task automatic test_resync();
      int e0 = err_seen;
      send_byte(8'h5A);
      send_frame(8'h01, 32'h0000_1000, 32'h1234_5678, 8'hDB, 1'b0);
      n_total++; if (frame_valid !== 1'b1) $display("FAIL resync_valid got %b want 1", frame_valid); else n_pass++;
      n_total++; if (frame_data !== 32'h1234_5678) $display("FAIL resync_data got %h want 12345678", frame_data); else n_pass++;
      consume();
      send_byte(8'h5A); send_byte(8'h00); send_byte(8'hA5);
      send_payload(8'h01, 32'h0000_1000, 32'h1234_5678, 8'hDB, 1'b0);
      repeat (2) @(negedge clk);
      n_total++; if (frame_valid !== 1'b0) $display("FAIL badsync_valid got %b want 0", frame_valid); else n_pass++;
      n_total++; if (err_seen !== e0) $display("FAIL badsync_no_error got %0d want %0d", err_seen, e0); else n_pass++;
   endtask

   task automatic test_timeout();
      int e0;
      send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h01);
      e0 = err_seen;
      repeat (15) @(negedge clk);
      n_total++; if (frame_error !== 1'b0 || err_seen !== e0) $display("FAIL timeout_early got err=%b seen=%0d want 0/%0d", frame_error, err_seen, e0); else n_pass++;
      @(negedge clk);
      n_total++; if (frame_error !== 1'b1) $display("FAIL timeout_error got %b want 1", frame_error); else n_pass++;
      n_total++; if (err_code !== 2'b10) $display("FAIL timeout_code got %b want 10", err_code); else n_pass++;
      send_frame(8'h01, 32'h0000_1000, 32'h1234_5678, 8'hDB, 1'b0);
      n_total++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h01) $display("FAIL timeout_recover got v=%b cmd=%h want 1/01", frame_valid, frame_cmd); else n_pass++;
      consume();
      // A byte arriving on the 16th idle cycle must be taken, not timed out.
      send_byte(8'h5A); send_byte(8'hA5);
      e0 = err_seen;
      repeat (15) @(negedge clk);
      send_payload(8'h02, 32'h0000_2000, 32'h0000_0001, 8'hDD, 1'b0);
      @(negedge clk);
      n_total++; if (err_seen !== e0) $display("FAIL timeout_edge_no_error got %0d want %0d", err_seen, e0); else n_pass++;
      n_total++; if (frame_valid !== 1'b1 || frame_addr !== 32'h0000_2000) $display("FAIL timeout_edge_frame got v=%b addr=%h want 1/00002000", frame_valid, frame_addr); else n_pass++;
      consume();
   endtask

   task automatic test_back_to_back();
      int e0;
      send_frame(8'h01, 32'h0000_1000, 32'h1234_5678, 8'hDB, 1'b0);
      send_frame(8'h02, 32'h0000_2000, 32'h0000_0001, 8'hDD, 1'b0);
      n_total++; if (frame_error !== 1'b1) $display("FAIL overrun_error got %b want 1", frame_error); else n_pass++;
      n_total++; if (err_code !== 2'b11) $display("FAIL overrun_code got %b want 11", err_code); else n_pass++;
      n_total++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h01 || frame_data !== 32'h1234_5678)
         $display("FAIL overrun_keep got v=%b cmd=%h data=%h want 1/01/12345678", frame_valid, frame_cmd, frame_data); else n_pass++;
      @(negedge clk);
      e0 = err_seen;
      send_frame(8'h02, 32'h0000_2000, 32'h0000_0001, 8'hDD, 1'b1);
      n_total++; if (frame_valid !== 1'b1 || frame_cmd !== 8'h02 || frame_addr !== 32'h0000_2000 || frame_data !== 32'h0000_0001)
         $display("FAIL replace_frame got v=%b cmd=%h addr=%h data=%h want 1/02/00002000/00000001", frame_valid, frame_cmd, frame_addr, frame_data); else n_pass++;
      n_total++; if (frame_error !== 1'b0) $display("FAIL replace_no_error got %b want 0", frame_error); else n_pass++;
      @(negedge clk);
      n_total++; if (err_seen !== e0 || err_code !== 2'b11) $display("FAIL replace_sticky got seen=%0d code=%b want %0d/11", err_seen, err_code, e0); else n_pass++;
   endtask

   task automatic test_reset_mid_frame();
      send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h03);
      for (int i = 0; i < 6; i++) send_byte(8'h11);
      sync_reset = 1'b1;
      @(negedge clk);
      sync_reset = 1'b0;
      n_total++; if (frame_valid !== 1'b0 || frame_cmd !== 8'h00 || frame_addr !== 32'h0 || frame_data !== 32'h0)
         $display("FAIL midreset_outputs got v=%b cmd=%h addr=%h data=%h want all 0", frame_valid, frame_cmd, frame_addr, frame_data); else n_pass++;
      n_total++; if (frame_error !== 1'b0 || err_code !== 2'b00) $display("FAIL midreset_err got %b/%b want 0/00", frame_error, err_code); else n_pass++;
      send_frame(8'h01, 32'h0000_1000, 32'h1234_5678, 8'hDB, 1'b0);
      n_total++; if (frame_valid !== 1'b1 || frame_addr !== 32'h0000_1000) $display("FAIL midreset_recover got v=%b addr=%h want 1/00001000", frame_valid, frame_addr); else n_pass++;
      consume();
   endtask

   task automatic test_enable_abort();
      int e0 = err_seen;
      send_byte(8'h5A); send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
      rx_enable = 1'b0;
      @(negedge clk);
      rx_enable = 1'b1;
      send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
      send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78); send_byte(8'hDB);
      repeat (20) @(negedge clk);
      n_total++; if (frame_valid !== 1'b0 || err_seen !== e0) $display("FAIL enable_abort got v=%b seen=%0d want 0/%0d", frame_valid, err_seen, e0); else n_pass++;
   endtask

   initial begin
      sync_reset = 1'b1; rx_enable = 1'b1; rx_byte_valid = 1'b0; rx_byte = 8'h00; frame_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_good_frame();
      test_bad_csum();
      test_resync();
      test_timeout();
      test_back_to_back();
      test_reset_mid_frame();
      test_enable_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
